// File: rtl/piso_pkg.sv
// Shared types and frame-geometry helpers for the PISO serializer.
// PISO_PARITY_EN lengthens every frame by one even-parity bit.
package piso_pkg;

   typedef enum logic {IDLE, SHIFT} state_t;

   function automatic int frame_len(input int data_width);
`ifdef PISO_PARITY_EN
      return data_width + 1;
`else
      return data_width;
`endif
   endfunction

   function automatic int cnt_width(input int data_width);
      return $clog2(frame_len(data_width));
   endfunction

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_CNT_W      = cnt_width(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/piso_serializer_8_bits_if.sv
// Load handshake and serial stream bundle for the PISO serializer.
interface piso_serializer_8_bits_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] Parallel_Data_In;
   logic                  Load_Valid_In;
   logic                  Load_Ready_Out;
   logic                  Serial_Data_Out;
   logic                  Serial_Valid_Out;
   logic                  Frame_Start_Out;
   logic                  Frame_End_Out;
   logic                  Busy_Out;

   modport master (
      output Parallel_Data_In, Load_Valid_In,
      input  Load_Ready_Out, Serial_Data_Out, Serial_Valid_Out,
             Frame_Start_Out, Frame_End_Out, Busy_Out
   );

   modport slave (
      input  Parallel_Data_In, Load_Valid_In,
      output Load_Ready_Out, Serial_Data_Out, Serial_Valid_Out,
             Frame_Start_Out, Frame_End_Out, Busy_Out
   );
endinterface

// File: rtl/piso_bit_counter.sv
// Bit-position counter: clear has priority over load, load over increment.
// tc flags the last position of a frame.
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int CNT_W    = DEFAULT_CNT_W,
   parameter int TERMINAL = frame_len(DEFAULT_DATA_WIDTH) - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

   assign tc = (count == CNT_W'(TERMINAL));

endmodule

// File: rtl/piso_serializer_8_bits.sv
// Parallel-in serial-out serializer with zero-gap back-to-back streaming.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer_8_bits
   import piso_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter bit MSB_FIRST  = 1'b1
) (
   input logic                     Clk_In,
   input logic                     Reset_In,
   piso_serializer_8_bits_if.slave bus
);

   localparam int FRAME_LEN = frame_len(DATA_WIDTH);
   localparam int CNT_W     = cnt_width(DATA_WIDTH);
   localparam logic [CNT_W-1:0] END_PREV = CNT_W'(FRAME_LEN - 2);
`ifdef PISO_PARITY_EN
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
`endif

   state_t                state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] shift_next;
   logic [CNT_W-1:0]      count;
   logic                  count_tc;
   logic                  ready;
   logic                  accept;
   logic                  cnt_clr;
   logic                  cnt_inc;
   logic                  data_q;
   logic                  valid_q;
   logic                  start_q;
   logic                  end_q;
`ifdef PISO_PARITY_EN
   logic                  parity_q;
`endif

   function automatic logic out_bit(input logic [DATA_WIDTH-1:0] v);
      return MSB_FIRST ? v[DATA_WIDTH-1] : v[0];
   endfunction

   assign shift_next = MSB_FIRST ? {shift_reg[DATA_WIDTH-2:0], 1'b0}
                                 : {1'b0, shift_reg[DATA_WIDTH-1:1]};

   // The reload window opens on the final bit so a waiting word follows with no gap.
   assign ready   = !Reset_In && ((state == IDLE) || ((state == SHIFT) && count_tc));
   assign accept  = bus.Load_Valid_In && ready;
   assign cnt_clr = (state == SHIFT) && count_tc && !accept;
   assign cnt_inc = (state == SHIFT) && !count_tc;

   piso_bit_counter #(
      .CNT_W    (CNT_W),
      .TERMINAL (FRAME_LEN - 1)
   ) u_counter (
      .clk      (Clk_In),
      .rst      (Reset_In),
      .clr      (cnt_clr),
      .load     (accept),
      .load_val ('0),
      .inc      (cnt_inc),
      .count    (count),
      .tc       (count_tc)
   );

   // Outputs are registered from next-cycle values, so flags line up with the bit they mark.
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         state     <= IDLE;
         shift_reg <= '0;
         data_q    <= 1'b0;
         valid_q   <= 1'b0;
         start_q   <= 1'b0;
         end_q     <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else if (accept) begin
         state     <= SHIFT;
         shift_reg <= bus.Parallel_Data_In;
         data_q    <= out_bit(bus.Parallel_Data_In);
         valid_q   <= 1'b1;
         start_q   <= 1'b1;
         end_q     <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q  <= ^bus.Parallel_Data_In;
`endif
      end else if (state == SHIFT) begin
         if (count_tc) begin
            state     <= IDLE;
            shift_reg <= '0;
            data_q    <= 1'b0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            end_q     <= 1'b0;
         end else begin
            shift_reg <= shift_next;
`ifdef PISO_PARITY_EN
            data_q    <= (count == LAST_DATA) ? parity_q : out_bit(shift_next);
`else
            data_q    <= out_bit(shift_next);
`endif
            valid_q   <= 1'b1;
            start_q   <= 1'b0;
            end_q     <= (count == END_PREV);
         end
      end
   end

   assign bus.Load_Ready_Out   = ready;
   assign bus.Serial_Data_Out  = data_q;
   assign bus.Serial_Valid_Out = valid_q;
   assign bus.Frame_Start_Out  = start_q;
   assign bus.Frame_End_Out    = end_q;
   assign bus.Busy_Out         = (state == SHIFT);

endmodule

// File: tb/tb_piso_serializer_8_bits.sv
// Self-checking bench: a stream-level model predicts every output cycle,
// and a SIPO-style capture checks whole frames against literal words.
module tb_piso_serializer_8_bits;

`ifdef PISO_PARITY_EN
   localparam int FL = 9;
   localparam logic [8:0] EXP_FRAMES [6] = '{9'h14A, 9'h078, 9'h1E0, 9'h1FE, 9'h000, 9'h00F};
`else
   localparam int FL = 8;
   localparam logic [8:0] EXP_FRAMES [6] = '{9'h0A5, 9'h03C, 9'h0F0, 9'h0FF, 9'h000, 9'h007};
`endif

   typedef struct packed {
      logic d;
      logic s;
      logic e;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   piso_serializer_8_bits_if #(.DATA_WIDTH(8)) bus ();

   piso_serializer_8_bits #(
      .DATA_WIDTH (8),
      .MSB_FIRST  (1'b1)
   ) dut (
      .Clk_In   (clk),
      .Reset_In (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int         n_cmp  = 0;
   int         n_fail = 0;
   ent_t       exp_q [$];
   ent_t       cur    = '0;
   logic       cur_v  = 1'b0;
   logic [8:0] frames [$];
   logic [8:0] cap    = '0;
   int         pulses = 0;
   int         vcount = 0;
   bit         window = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: an accepted word becomes FL queued output cycles; ready when nothing follows the current one.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         cur_v = 1'b0;
         cur   = '0;
      end else begin
         if (bus.Load_Valid_In && exp_q.size() == 0) begin
            for (int i = 0; i < FL; i++) begin
               ent_t e;
               e.d = (i < 8) ? bus.Parallel_Data_In[7-i] : ^bus.Parallel_Data_In;
               e.s = (i == 0);
               e.e = (i == FL - 1);
               exp_q.push_back(e);
            end
         end
         if (exp_q.size() > 0) begin
            cur   = exp_q.pop_front();
            cur_v = 1'b1;
         end else begin
            cur_v = 1'b0;
            cur   = '0;
         end
      end
   end

   always @(negedge clk) begin
      check("serial_data",  bus.Serial_Data_Out,  cur_v ? cur.d : 1'b0);
      check("serial_valid", bus.Serial_Valid_Out, cur_v);
      check("frame_start",  bus.Frame_Start_Out,  cur_v ? cur.s : 1'b0);
      check("frame_end",    bus.Frame_End_Out,    cur_v ? cur.e : 1'b0);
      check("busy",         bus.Busy_Out,         cur_v);
      check("load_ready",   bus.Load_Ready_Out,   !rst && (exp_q.size() == 0));
      if (rst) begin
         cap = '0;
      end else if (bus.Serial_Valid_Out) begin
         cap = bus.Frame_Start_Out ? {8'b0, bus.Serial_Data_Out} : {cap[7:0], bus.Serial_Data_Out};
         if (bus.Frame_End_Out) frames.push_back(cap);
      end
      if (window) begin
         if (bus.Serial_Valid_Out) vcount++;
         if (bus.Load_Ready_Out && bus.Busy_Out) pulses++;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Presents a word and returns just after the edge that accepted it, valid still high.
   task automatic send(input logic [7:0] w);
      bit   done = 1'b0;
      logic r;
      bus.Load_Valid_In    = 1'b1;
      bus.Parallel_Data_In = w;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         r = bus.Load_Ready_Out;
         @(posedge clk);
         #2;
         if (r) done = 1'b1;
      end
      check("send_accept", done, 1);
   endtask

   initial begin
      bus.Load_Valid_In    = 1'b0;
      bus.Parallel_Data_In = '0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;

      // Idle after reset.
      wait_cycles(5);
      check("idle_ready", bus.Load_Ready_Out, 1);
      check("idle_valid", bus.Serial_Valid_Out, 0);
      check("idle_data",  bus.Serial_Data_Out, 0);
      check("idle_start", bus.Frame_Start_Out, 0);
      check("idle_end",   bus.Frame_End_Out, 0);

      // Single word.
      send(8'hA5);
      bus.Load_Valid_In = 1'b0;
      wait_cycles(FL + 2);
      check("frame_a5", (frames.size() > 0) ? frames[$] : 9'h1FF, EXP_FRAMES[0]);

      // Back-to-back words with valid held.
      pulses = 0;
      vcount = 0;
      window = 1'b1;
      send(8'h3C);
      send(8'hF0);
      bus.Load_Valid_In = 1'b0;
      wait_cycles(FL + 2);
      window = 1'b0;
      check("b2b_valid_bits", vcount, 2 * FL);
      check("b2b_ready_pulses", pulses, 2);

      // Mid-frame valid and data changes must not disturb the running frame.
      send(8'hFF);
      bus.Load_Valid_In = 1'b0;
      wait_cycles(2);
      bus.Load_Valid_In    = 1'b1;
      bus.Parallel_Data_In = 8'h55;
      wait_cycles(1);
      send(8'h00);
      bus.Load_Valid_In = 1'b0;
      wait_cycles(FL + 2);
      check("mid_frame_count", frames.size(), 5);

      // Asynchronous reset between edges during bit 4.
      send(8'hFF);
      bus.Load_Valid_In = 1'b0;
      wait_cycles(3);
      check("pre_reset_valid", bus.Serial_Valid_Out, 1);
      #1 rst = 1'b1;
      #1;
      check("rst_data",  bus.Serial_Data_Out, 0);
      check("rst_valid", bus.Serial_Valid_Out, 0);
      check("rst_busy",  bus.Busy_Out, 0);
      check("rst_ready", bus.Load_Ready_Out, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      wait_cycles(3);
      check("post_rst_ready", bus.Load_Ready_Out, 1);
      check("post_rst_busy",  bus.Busy_Out, 0);
      check("post_rst_frames", frames.size(), 5);

      // Final word, with parity bit when enabled.
      send(8'h07);
      bus.Load_Valid_In = 1'b0;
      wait_cycles(FL + 2);

      check("frame_count", frames.size(), 6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("frame_%0d", i), (i < frames.size()) ? frames[i] : 9'h1FF, EXP_FRAMES[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
